rotor_stepper: RTL and testbench
================================

ROTOR_STEPPER -- requirements
Module: rotor_stepper

Interface
REQ-001 Parameter W, default 5, character/position width in bits.
REQ-002 Parameter N, default 26, alphabet size; legal range 2 <= N <= 2^W - 1.
REQ-003 Parameter NOTCH, default 16, position (0..N-1) at which turnover carry is generated.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 cfg_we  in  1  wiring-table write strobe.
REQ-007 cfg_addr  in  W  input letter being programmed (1..N).
REQ-008 cfg_data  in  W  output letter it maps to (1..N).
REQ-009 pos_load  in  1  load rotor position from pos_val.
REQ-010 pos_val  in  W  position to load (0..N-1).
REQ-011 step_in  in  1  advance rotor one position.
REQ-012 in_valid  in  1  translation request.
REQ-013 in_dir  in  1  0 = forward path, 1 = reverse (inverse) path.
REQ-014 in_char  in  W  letter to translate (1..N; 0 is invalid).
REQ-015 out_valid  out  1  registered translation valid.
REQ-016 out_char  out  W  translated letter.
REQ-017 step_out  out  1  one-cycle turnover carry to next rotor.
REQ-018 pos  out  W  current rotor position.
REQ-019 err  out  1  one-cycle pulse on illegal input or config.

Function
REQ-020 Block SHALL hold two N-entry tables of W bits: fwd[0..N-1] and inv[0..N-1], letters encoded 1..N.
REQ-021 cfg_we with cfg_addr and cfg_data both in 1..N SHALL write fwd[cfg_addr-1]=cfg_data and inv[cfg_data-1]=cfg_addr on the same edge; otherwise no write, err=1 next cycle.
REQ-022 Permutation integrity of the programmed table is the controller's responsibility; block performs no consistency check.
REQ-023 Forward translation: idx=(in_char-1+pos) mod N; m=fwd[idx]; out_char=((m-1-pos+N) mod N)+1.
REQ-024 Reverse translation: identical, using inv in place of fwd.
REQ-025 Latency SHALL be 1 cycle: in_valid at edge k -> out_valid=1 and out_char after edge k; out_valid=0 when in_valid=0, out_char holds last value.
REQ-026 in_valid with in_char=0 or >N SHALL give out_valid=1, out_char=0, err=1.
REQ-027 Intermediate sums SHALL be computed at W+1 bits; no result outside 1..N for legal inputs.
REQ-028 Translation SHALL use pos and tables as registered before the edge; a same-cycle step, load or cfg write affects only later requests.
REQ-029 step_in SHALL set pos=(pos+1) mod N; pos=N-1 wraps to 0.
REQ-030 step_out SHALL be 1 for exactly the cycle after a step that moves pos from NOTCH to NOTCH+1 (mod N); otherwise 0.
REQ-031 pos_load SHALL set pos=pos_val, has priority over step_in in the same cycle, and never generates step_out; pos_val >= N loads 0 and pulses err.
REQ-032 Simultaneous cfg_we, pos_load/step_in and in_valid SHALL all be honoured independently in one cycle.

Reset
REQ-033 On rst assertion, immediately and without clock: pos=0, out_valid=0, out_char=0, step_out=0, err=0, fwd[i]=inv[i]=i+1 (identity).
REQ-034 Reset asserted mid-operation SHALL discard any in-flight translation; no out_valid pulse after release until a new in_valid.
REQ-035 First edge after rst deassertion SHALL behave as a normal operating edge.

Verification
REQ-036 Reset, pos=0, forward in_char=1 -> next cycle out_valid=1, out_char=1, err=0.
REQ-037 Write addr=1 data=6, pos=0: forward in=1 -> 6; reverse in=6 -> 1.
REQ-038 Write addr=2 data=15, pos_load 1, forward in=1 -> out_char=14.
REQ-039 pos_load 16, step_in -> pos=17, step_out=1 one cycle; pos_load 25, step_in -> pos=0, step_out=0; pos_load+step_in together with pos_val=5 -> pos=5.
REQ-040 in_char=0 or 27 -> out_char=0, err=1; cfg_addr=0 -> table unchanged, err=1.
REQ-041 rst pulsed with in_valid high and pos=9 -> pos=0, out_valid=0, table identity, in=4 afterwards -> 4.

Source files
------------

// File: rtl/rotor_stepper.sv
// Single cipher rotor: programmable forward/inverse wiring tables, a stepping
// position register with notch turnover carry, and a one-cycle translation path.
module rotor_stepper #(
  parameter int W     = 5,
  parameter int N     = 26,
  parameter int NOTCH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_we,
  input  logic [W-1:0] cfg_addr,
  input  logic [W-1:0] cfg_data,
  input  logic         pos_load,
  input  logic [W-1:0] pos_val,
  input  logic         step_in,
  input  logic         in_valid,
  input  logic         in_dir,
  input  logic [W-1:0] in_char,
  output logic         out_valid,
  output logic [W-1:0] out_char,
  output logic         step_out,
  output logic [W-1:0] pos,
  output logic         err
);

  localparam logic [W:0]   NW      = (W+1)'(N);
  localparam logic [W:0]   ONE     = (W+1)'(1);
  localparam logic [W-1:0] LAST    = W'(N - 1);
  localparam logic [W-1:0] NOTCH_W = W'(NOTCH);

  logic [W-1:0] fwd_q [N];
  logic [W-1:0] inv_q [N];

  logic [W-1:0] pos_q, pos_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_char_q, out_char_d;
  logic         step_out_q, step_out_d;
  logic         err_q, err_d;

  logic         ch_ok, cfg_ok, pval_ok;
  logic [W:0]   sum_idx, sum_out;
  logic [W-1:0] idx, m, xlat;

  always_comb begin
    ch_ok   = (in_char != '0) && ({1'b0, in_char} <= NW);
    cfg_ok  = (cfg_addr != '0) && ({1'b0, cfg_addr} <= NW) &&
              (cfg_data != '0) && ({1'b0, cfg_data} <= NW);
    pval_ok = ({1'b0, pos_val} < NW);

    // Entry index: (in_char-1+pos) mod N, forced to 0 for illegal letters so
    // the table read always stays in range.
    sum_idx = {1'b0, in_char} - ONE + {1'b0, pos_q};
    if (sum_idx >= NW) sum_idx = sum_idx - NW;
    idx = ch_ok ? sum_idx[W-1:0] : '0;
    m   = in_dir ? inv_q[idx] : fwd_q[idx];

    sum_out = {1'b0, m} - ONE + NW - {1'b0, pos_q};
    if (sum_out >= NW) sum_out = sum_out - NW;
    xlat = ch_ok ? (sum_out[W-1:0] + W'(1)) : '0;

    out_valid_d = in_valid;
    out_char_d  = in_valid ? xlat : out_char_q;

    pos_d      = pos_q;
    step_out_d = 1'b0;
    if (pos_load) begin
      pos_d = pval_ok ? pos_val : '0;
    end else if (step_in) begin
      pos_d      = (pos_q == LAST) ? '0 : pos_q + W'(1);
      step_out_d = (pos_q == NOTCH_W);
    end

    err_d = (cfg_we && !cfg_ok) || (pos_load && !pval_ok) || (in_valid && !ch_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q       <= '0;
      out_valid_q <= 1'b0;
      out_char_q  <= '0;
      step_out_q  <= 1'b0;
      err_q       <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        fwd_q[i] <= W'(i + 1);
        inv_q[i] <= W'(i + 1);
      end
    end else begin
      pos_q       <= pos_d;
      out_valid_q <= out_valid_d;
      out_char_q  <= out_char_d;
      step_out_q  <= step_out_d;
      err_q       <= err_d;
      if (cfg_we && cfg_ok) begin
        fwd_q[cfg_addr - W'(1)] <= cfg_data;
        inv_q[cfg_data - W'(1)] <= cfg_addr;
      end
    end
  end

  assign pos       = pos_q;
  assign out_valid = out_valid_q;
  assign out_char  = out_char_q;
  assign step_out  = step_out_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rotor_stepper.sv
// Directed bench for rotor_stepper (default W=5, N=26, NOTCH=16); expected
// values are worked by hand from the rotor equations.
module tb_rotor_stepper;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we, pos_load, step_in, in_valid, in_dir;
  logic [4:0] cfg_addr, cfg_data, pos_val, in_char;
  logic       out_valid, step_out, err;
  logic [4:0] out_char, pos;

  int tests = 0;
  int fails = 0;

  rotor_stepper #(.W(5), .N(26), .NOTCH(16)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .pos_load(pos_load), .pos_val(pos_val), .step_in(step_in),
    .in_valid(in_valid), .in_dir(in_dir), .in_char(in_char),
    .out_valid(out_valid), .out_char(out_char), .step_out(step_out),
    .pos(pos), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic xlate(input logic dir, input logic [4:0] ch);
    in_valid = 1'b1;
    in_dir   = dir;
    in_char  = ch;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic load_pos(input logic [4:0] v);
    pos_load = 1'b1;
    pos_val  = v;
    cyc();
    pos_load = 1'b0;
  endtask

  task automatic do_step();
    step_in = 1'b1;
    cyc();
    step_in = 1'b0;
  endtask

  task automatic cfg(input logic [4:0] a, input logic [4:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    cyc();
    cfg_we   = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cfg_we = 0; pos_load = 0; step_in = 0; in_valid = 0; in_dir = 0;
    cfg_addr = 0; cfg_data = 0; pos_val = 0; in_char = 0;
    #2;
    check_eq("rst_pos", pos, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_char", out_char, 0);
    check_eq("rst_step_out", step_out, 0);
    check_eq("rst_err", err, 0);
    #10 rst = 1'b0;
    cyc();

    // identity after reset
    xlate(0, 1);
    check_eq("id_valid", out_valid, 1);
    check_eq("id_char", out_char, 1);
    check_eq("id_err", err, 0);
    cyc();
    check_eq("idle_valid", out_valid, 0);
    check_eq("idle_hold", out_char, 1);

    cfg(1, 6);
    check_eq("cfg_ok_err", err, 0);
    xlate(0, 1);
    check_eq("fwd_1_6", out_char, 6);
    xlate(1, 6);
    check_eq("rev_6_1", out_char, 1);

    // cfg write and position load honoured in the same cycle
    cfg_we = 1; cfg_addr = 2; cfg_data = 15; pos_load = 1; pos_val = 1;
    cyc();
    cfg_we = 0; pos_load = 0;
    check_eq("load_pos1", pos, 1);
    xlate(0, 1);
    check_eq("fwd_pos1", out_char, 14);
    xlate(1, 14);
    check_eq("rev_pos1", out_char, 1);

    load_pos(16);
    check_eq("pos16", pos, 16);
    do_step();
    check_eq("step_pos17", pos, 17);
    check_eq("notch_carry", step_out, 1);
    cyc();
    check_eq("carry_1cyc", step_out, 0);
    load_pos(15);
    do_step();
    check_eq("step_pos16", pos, 16);
    check_eq("no_carry_15", step_out, 0);
    load_pos(25);
    do_step();
    check_eq("wrap_pos", pos, 0);
    check_eq("wrap_no_carry", step_out, 0);
    pos_load = 1; step_in = 1; pos_val = 5;
    cyc();
    pos_load = 0; step_in = 0;
    check_eq("load_prio", pos, 5);
    check_eq("load_prio_carry", step_out, 0);
    load_pos(16);
    pos_load = 1; step_in = 1; pos_val = 16;
    cyc();
    pos_load = 0; step_in = 0;
    check_eq("load_no_carry", step_out, 0);
    load_pos(26);
    check_eq("bad_load_pos", pos, 0);
    check_eq("bad_load_err", err, 1);

    xlate(0, 0);
    check_eq("ch0_valid", out_valid, 1);
    check_eq("ch0_char", out_char, 0);
    check_eq("ch0_err", err, 1);
    xlate(0, 27);
    check_eq("ch27_char", out_char, 0);
    check_eq("ch27_err", err, 1);
    cfg(0, 3);
    check_eq("cfg_addr0_err", err, 1);
    xlate(0, 3);
    check_eq("cfg_addr0_nowrite", out_char, 3);
    check_eq("legal_err_clear", err, 0);
    cfg(3, 0);
    check_eq("cfg_data0_err", err, 1);
    xlate(0, 3);
    check_eq("cfg_data0_nowrite", out_char, 3);

    // modular wrap of the index and output offset at pos=25
    load_pos(25);
    xlate(0, 2);
    check_eq("wrap_fwd_2", out_char, 7);
    xlate(0, 26);
    check_eq("wrap_fwd_26", out_char, 26);
    // a same-cycle step must not affect the request translated alongside it
    step_in = 1;
    xlate(0, 2);
    step_in = 0;
    check_eq("same_cyc_xlate", out_char, 7);
    check_eq("same_cyc_pos", pos, 0);

    load_pos(9);
    xlate(0, 4);
    in_valid = 1; in_char = 4;
    cyc();
    check_eq("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_pos", pos, 0);
    check_eq("mid_rst_valid", out_valid, 0);
    in_valid = 0;
    cyc();
    #2 rst = 1'b0;
    cyc();
    check_eq("post_rst_valid", out_valid, 0);
    xlate(0, 1);
    check_eq("post_rst_id1", out_char, 1);
    xlate(0, 4);
    check_eq("post_rst_id4", out_char, 4);
    xlate(1, 6);
    check_eq("post_rst_rev6", out_char, 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
